// File: rtl/show_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : show_pkg
//  Description : Shared types and constants for the show_uart_tx block.
//                - state_t      : serialiser state encoding
//                - c_MAX_BYTES  : default show buffer capacity (bytes)
//                - c_IDLE_LEVEL : UART line level when nothing is sent
//                Optional feature macro: SHOW_UART_PARITY_EN adds ST_PARITY.
//  Revision    : 1.0 - initial release
// ============================================================================
package show_pkg;

    localparam int   c_MAX_BYTES  = 16;
    localparam logic c_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SHOW_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : Serialises one byte per frame: start(0), 8 data bits
//                LSB-first, optional even parity, stop(1). Every bit is held
//                CLK_DIV cycles. A new byte offered during the last cycle of
//                a stop bit is started immediately (back-to-back frames).
//  Ports       : clk, reset (async, active high)
//                byte_valid / byte_data : next byte to send
//                byte_ack               : byte_data taken this cycle
//                state                  : current serialiser state
//                txd                    : registered serial output
//  Config      : SHOW_UART_PARITY_EN inserts an even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import show_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ack,
    output state_t     state,
    output logic       txd
);

    localparam int                 c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]         r_bit,   w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_txd,   w_txd_nxt;
    logic               w_tick;
`ifdef SHOW_UART_PARITY_EN
    logic               r_par,   w_par_nxt;
`endif

    assign state  = r_state;
    assign txd    = r_txd;
    assign w_tick = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= c_IDLE_LEVEL;
`ifdef SHOW_UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
`ifdef SHOW_UART_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        byte_ack    = 1'b0;
`ifdef SHOW_UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        // Bit timer free-runs 0..CLK_DIV-1 in every active state.
        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (byte_valid) begin
                    byte_ack    = 1'b1;
                    w_state_nxt = ST_START;
                    w_shift_nxt = byte_data;
                    w_bit_nxt   = 3'd0;
                    w_cnt_nxt   = '0;
                    w_txd_nxt   = 1'b0;
`ifdef SHOW_UART_PARITY_EN
                    w_par_nxt   = ^byte_data;
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
`ifdef SHOW_UART_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_txd_nxt   = r_par;
`else
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        // Look one bit ahead so txd stays a pure register.
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                    end
                end
            end
`ifdef SHOW_UART_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (byte_valid) begin
                        byte_ack    = 1'b1;
                        w_state_nxt = ST_START;
                        w_shift_nxt = byte_data;
                        w_bit_nxt   = 3'd0;
                        w_txd_nxt   = 1'b0;
`ifdef SHOW_UART_PARITY_EN
                        w_par_nxt   = ^byte_data;
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_txd_nxt   = c_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_txd_nxt   = c_IDLE_LEVEL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/show_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : show_uart_tx
//  Description : Latches a packet of up to MAX_BYTES right-aligned bytes and
//                sends them over a UART line, most-significant byte first,
//                frames back-to-back. Per-byte framing lives in uart_byte_tx.
//  Ports       : clk, reset (async, active high)
//                show_data/show_len/show_valid/show_ready : packet handshake
//                txd  : serial line, idle high
//                busy : a frame bit is currently on txd
//  Config      : SHOW_UART_PARITY_EN (handled in uart_byte_tx) adds parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module show_uart_tx
    import show_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int MAX_BYTES = c_MAX_BYTES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*MAX_BYTES-1:0] show_data,
    input  logic [4:0]             show_len,
    input  logic                   show_valid,
    output logic                   show_ready,
    output logic                   txd,
    output logic                   busy
);

    localparam int c_W = 8 * MAX_BYTES;

    logic           r_rdy_en;
    logic [c_W-1:0] r_data;
    logic [4:0]     r_remaining;

    logic           w_accept;
    logic [4:0]     w_len;
    logic [c_W-1:0] w_aligned;
    logic           w_byte_valid;
    logic           w_byte_ack;
    logic [7:0]     w_byte_data;
    state_t         w_state;

    // r_rdy_en keeps show_ready low until the first edge after reset release.
    assign show_ready = r_rdy_en && (w_state == ST_IDLE);
    assign busy       = (w_state != ST_IDLE);
    assign w_accept   = show_valid && show_ready;
    assign w_len      = (show_len > 5'(MAX_BYTES)) ? 5'(MAX_BYTES) : show_len;

    // Left-align the packet so the byte to send next is always the top byte.
    assign w_aligned  = show_data << (8 * (MAX_BYTES - int'(w_len)));

    // On the accept cycle the first byte bypasses the latch so its start
    // bit appears on txd the very next cycle.
    assign w_byte_valid = w_accept ? (w_len != 5'd0) : (r_remaining != 5'd0);
    assign w_byte_data  = w_accept ? w_aligned[c_W-1 -: 8] : r_data[c_W-1 -: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_en    <= 1'b0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_data      <= w_aligned << 8;
                r_remaining <= (w_len != 5'd0) ? w_len - 5'd1 : 5'd0;
            end else if (w_byte_ack) begin
                r_data      <= r_data << 8;
                r_remaining <= r_remaining - 5'd1;
            end
        end
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_ack   (w_byte_ack),
        .state      (w_state),
        .txd        (txd)
    );

endmodule
`default_nettype wire
